// File: rtl/data_mem_if.sv
// Load/store port between a CPU datapath (master) and its data memory (slave):
// a valid/ready request channel and a one-cycle response pulse.
interface data_mem_if;
    logic        MEM_req_valid;
    logic        MEM_req_write;
    logic [1:0]  MEM_length;
    logic        MEM_read_signed;
    logic [31:0] MEM_address;
    logic [31:0] MEM_write_data;
    logic        MEM_req_ready;
    logic        MEM_resp_valid;
    logic [31:0] MEM_read_data;
    logic        MEM_error;

    modport master (
        output MEM_req_valid, MEM_req_write, MEM_length, MEM_read_signed,
               MEM_address, MEM_write_data,
        input  MEM_req_ready, MEM_resp_valid, MEM_read_data, MEM_error
    );

    modport slave (
        input  MEM_req_valid, MEM_req_write, MEM_length, MEM_read_signed,
               MEM_address, MEM_write_data,
        output MEM_req_ready, MEM_resp_valid, MEM_read_data, MEM_error
    );
endinterface

// File: rtl/data_mem_responder.sv
// Byte-addressed little-endian data memory on a word-wide RAM; serves byte/half/word
// accesses (including word-crossing ones) in one or two RAM cycles.
module data_mem_responder #(
    parameter int          DEPTH_WORDS  = 1024,
    parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000
) (
    input  logic     SYS_clk,
    input  logic     SYS_reset,
    data_mem_if.slave mem
);
    localparam int          ADDR_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] RAM_BYTES = 33'(DEPTH_WORDS) * 33'd4;

    typedef enum logic [1:0] {IDLE, FIRST, SECOND, DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] w0_q, w0_d;
    logic [1:0]        off_q, off_d;
    logic [1:0]        len_q, len_d;
    logic              write_q, write_d;
    logic              signed_q, signed_d;
    logic              err_q, err_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [23:0]       lo_q;
    logic [31:0]       read_data_q;

    logic [31:0] mem_q [DEPTH_WORDS] = '{default: '0};
    logic [31:0] ram_rd_q;

    // Request decode: range check done in offset space so a below-base address borrows
    logic [32:0] rel_addr;
    logic [32:0] last_rel;
    logic [2:0]  n_bytes;
    logic        out_of_range;

    always_comb begin
        n_bytes = 3'd0;
        case (mem.MEM_length)
            2'b01:   n_bytes = 3'd1;
            2'b10:   n_bytes = 3'd2;
            2'b11:   n_bytes = 3'd4;
            default: n_bytes = 3'd0;
        endcase
        rel_addr     = {1'b0, mem.MEM_address} - {1'b0, BASE_ADDRESS};
        last_rel     = {1'b0, rel_addr[31:0]} + {30'b0, n_bytes} - 33'd1;
        out_of_range = rel_addr[32] || (last_rel >= RAM_BYTES);
    end

    // Lane placement of the latched access across word w0 (low) and w0+1 (high)
    logic [3:0]  len_mask;
    logic [7:0]  be_full;
    logic [63:0] wide_wdata;
    logic        crossing;

    always_comb begin
        len_mask = 4'b0000;
        case (len_q)
            2'b01:   len_mask = 4'b0001;
            2'b10:   len_mask = 4'b0011;
            2'b11:   len_mask = 4'b1111;
            default: len_mask = 4'b0000;
        endcase
        be_full    = {4'b0000, len_mask} << off_q;
        wide_wdata = {32'b0, wdata_q} << {off_q, 3'b000};
        crossing   = |be_full[7:4];
    end

    // FSM
    always_comb begin
        state_d  = state_q;
        w0_d     = w0_q;
        off_d    = off_q;
        len_d    = len_q;
        write_d  = write_q;
        signed_d = signed_q;
        err_d    = err_q;
        wdata_d  = wdata_q;
        case (state_q)
            IDLE: begin
                if (mem.MEM_req_valid) begin
                    w0_d     = rel_addr[ADDR_W+1:2];
                    off_d    = mem.MEM_address[1:0];
                    len_d    = mem.MEM_length;
                    write_d  = mem.MEM_req_write;
                    signed_d = mem.MEM_read_signed;
                    wdata_d  = mem.MEM_write_data;
                    if (mem.MEM_length == 2'b00) begin
                        err_d   = 1'b0;
                        state_d = DONE;
                    end else if (out_of_range) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        err_d   = 1'b0;
                        state_d = FIRST;
                    end
                end
            end
            FIRST:   state_d = crossing ? SECOND : DONE;
            SECOND:  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // RAM port; the write is gated by reset so an interrupted second half never lands
    logic              ram_we;
    logic [ADDR_W-1:0] ram_idx;
    logic [3:0]        ram_be;
    logic [31:0]       ram_wdata;

    always_comb begin
        ram_we    = write_q && !SYS_reset && ((state_q == FIRST) || (state_q == SECOND));
        ram_idx   = (state_q == SECOND) ? (w0_q + ADDR_W'(1)) : w0_q;
        ram_be    = (state_q == SECOND) ? be_full[7:4] : be_full[3:0];
        ram_wdata = (state_q == SECOND) ? wide_wdata[63:32] : wide_wdata[31:0];
    end

    always_ff @(posedge SYS_clk) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (ram_be[i]) mem_q[ram_idx][i*8 +: 8] <= ram_wdata[i*8 +: 8];
            end
        end
        ram_rd_q <= mem_q[ram_idx];
    end

    // Load assembly: byte A lands in bits [7:0]; lo_q holds the upper bytes of w0
    logic [31:0] aligned;
    logic [31:0] load_result;

    always_comb begin
        aligned = ram_rd_q >> {off_q, 3'b000};
        if (crossing) begin
            case (off_q)
                2'd1:    aligned = {ram_rd_q[7:0],  lo_q[23:0]};
                2'd2:    aligned = {ram_rd_q[15:0], lo_q[23:8]};
                2'd3:    aligned = {ram_rd_q[23:0], lo_q[23:16]};
                default: aligned = ram_rd_q;
            endcase
        end
        load_result = 32'b0;
        if (!write_q && !err_q) begin
            case (len_q)
                2'b01:   load_result = {{24{signed_q & aligned[7]}},  aligned[7:0]};
                2'b10:   load_result = {{16{signed_q & aligned[15]}}, aligned[15:0]};
                2'b11:   load_result = aligned;
                default: load_result = 32'b0;
            endcase
        end
    end

    always_ff @(posedge SYS_clk) begin
        if (SYS_reset) begin
            state_q     <= IDLE;
            w0_q        <= '0;
            off_q       <= 2'b00;
            len_q       <= 2'b00;
            write_q     <= 1'b0;
            signed_q    <= 1'b0;
            err_q       <= 1'b0;
            wdata_q     <= 32'b0;
            lo_q        <= 24'b0;
            read_data_q <= 32'b0;
        end else begin
            state_q  <= state_d;
            w0_q     <= w0_d;
            off_q    <= off_d;
            len_q    <= len_d;
            write_q  <= write_d;
            signed_q <= signed_d;
            err_q    <= err_d;
            wdata_q  <= wdata_d;
            if (state_q == SECOND) lo_q <= ram_rd_q[31:8];
            if (state_q == DONE) read_data_q <= load_result;
        end
    end

    assign mem.MEM_req_ready  = (state_q == IDLE);
    assign mem.MEM_resp_valid = (state_q == DONE);
    assign mem.MEM_read_data  = (state_q == DONE) ? load_result : read_data_q;
    assign mem.MEM_error      = (state_q == DONE) && err_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: table of transactions with expected data,
// error and latency, plus a reset-during-second-half sequence.
module tb_data_mem_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    data_mem_if mem_if ();

    data_mem_responder #(.DEPTH_WORDS(1024), .BASE_ADDRESS(32'h0000_0000)) dut (
        .SYS_clk  (clk),
        .SYS_reset(rst),
        .mem      (mem_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [1:0]  len;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        logic        exp_err;
        int          exp_lat;
    } txn_t;

    localparam int NV = 25;
    txn_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_txn(input txn_t t, input int idx);
        int waited;
        int edges;
        waited = 0;
        while (!mem_if.MEM_req_ready && waited < 10) begin
            @(posedge clk); #1;
            waited++;
        end
        chk("ready_before_req", 32'(mem_if.MEM_req_ready), 32'd1);
        mem_if.MEM_req_valid   = 1'b1;
        mem_if.MEM_req_write   = t.wr;
        mem_if.MEM_length      = t.len;
        mem_if.MEM_read_signed = t.sgn;
        mem_if.MEM_address     = t.addr;
        mem_if.MEM_write_data  = t.wdata;
        @(posedge clk); #1;
        mem_if.MEM_req_valid = 1'b0;
        edges = 1;
        while (!mem_if.MEM_resp_valid && edges < 8) begin
            @(posedge clk); #1;
            edges++;
        end
        $display("txn %0d: wr=%0d len=%0d sgn=%0d addr=%h wdata=%h -> data=%h err=%0d lat=%0d",
                 idx, t.wr, t.len, t.sgn, t.addr, t.wdata,
                 mem_if.MEM_read_data, mem_if.MEM_error, edges);
        chk("resp_valid", 32'(mem_if.MEM_resp_valid), 32'd1);
        chk("latency", 32'(edges), 32'(t.exp_lat));
        chk("read_data", mem_if.MEM_read_data, t.exp_data);
        chk("error", 32'(mem_if.MEM_error), 32'(t.exp_err));
        @(posedge clk); #1;
        chk("resp_one_cycle", 32'(mem_if.MEM_resp_valid), 32'd0);
        chk("ready_after_done", 32'(mem_if.MEM_req_ready), 32'd1);
        chk("read_data_hold", mem_if.MEM_read_data, t.exp_data);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pulses;
        txn_t t;

        //            wr    len    sgn   addr          wdata         exp_data      err   lat
        vecs[0]  = '{1'b1, 2'b11, 1'b0, 32'h0000_0010, 32'h8000_00FF, 32'h0000_0000, 1'b0, 2};
        vecs[1]  = '{1'b0, 2'b11, 1'b0, 32'h0000_0010, 32'h0,         32'h8000_00FF, 1'b0, 2};
        vecs[2]  = '{1'b0, 2'b01, 1'b1, 32'h0000_0010, 32'h0,         32'hFFFF_FFFF, 1'b0, 2};
        vecs[3]  = '{1'b0, 2'b01, 1'b0, 32'h0000_0010, 32'h0,         32'h0000_00FF, 1'b0, 2};
        vecs[4]  = '{1'b0, 2'b10, 1'b1, 32'h0000_0012, 32'h0,         32'hFFFF_8000, 1'b0, 2};
        vecs[5]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0012, 32'h0,         32'h0000_8000, 1'b0, 2};
        vecs[6]  = '{1'b1, 2'b11, 1'b0, 32'h0000_001E, 32'hAABB_CCDD, 32'h0000_0000, 1'b0, 3};
        vecs[7]  = '{1'b0, 2'b11, 1'b0, 32'h0000_001C, 32'h0,         32'hCCDD_0000, 1'b0, 2};
        vecs[8]  = '{1'b0, 2'b11, 1'b0, 32'h0000_0020, 32'h0,         32'h0000_AABB, 1'b0, 2};
        vecs[9]  = '{1'b0, 2'b11, 1'b0, 32'h0000_001E, 32'h0,         32'hAABB_CCDD, 1'b0, 3};
        vecs[10] = '{1'b0, 2'b10, 1'b1, 32'h0000_001F, 32'h0,         32'hFFFF_BBCC, 1'b0, 3};
        vecs[11] = '{1'b0, 2'b11, 1'b0, 32'h0000_0FFE, 32'h0,         32'h0000_0000, 1'b1, 1};
        vecs[12] = '{1'b1, 2'b11, 1'b0, 32'h0000_0FFE, 32'h1122_3344, 32'h0000_0000, 1'b1, 1};
        vecs[13] = '{1'b0, 2'b11, 1'b0, 32'h0000_0FFC, 32'h0,         32'h0000_0000, 1'b0, 2};
        vecs[14] = '{1'b0, 2'b01, 1'b0, 32'h0000_0FFF, 32'h0,         32'h0000_0000, 1'b0, 2};
        vecs[15] = '{1'b0, 2'b10, 1'b0, 32'h0000_0FFF, 32'h0,         32'h0000_0000, 1'b1, 1};
        vecs[16] = '{1'b0, 2'b11, 1'b0, 32'hFFFF_FFFE, 32'h0,         32'h0000_0000, 1'b1, 1};
        vecs[17] = '{1'b0, 2'b00, 1'b0, 32'h0000_0010, 32'h0,         32'h0000_0000, 1'b0, 1};
        vecs[18] = '{1'b1, 2'b01, 1'b0, 32'h0000_0021, 32'h1234_565A, 32'h0000_0000, 1'b0, 2};
        vecs[19] = '{1'b0, 2'b11, 1'b0, 32'h0000_0020, 32'h0,         32'h0000_5ABB, 1'b0, 2};
        vecs[20] = '{1'b1, 2'b10, 1'b0, 32'h0000_0023, 32'hFFFF_7E81, 32'h0000_0000, 1'b0, 3};
        vecs[21] = '{1'b0, 2'b11, 1'b0, 32'h0000_0020, 32'h0,         32'h8100_5ABB, 1'b0, 2};
        vecs[22] = '{1'b0, 2'b11, 1'b0, 32'h0000_0024, 32'h0,         32'h0000_007E, 1'b0, 2};
        vecs[23] = '{1'b0, 2'b10, 1'b1, 32'h0000_0023, 32'h0,         32'h0000_7E81, 1'b0, 3};
        vecs[24] = '{1'b0, 2'b01, 1'b1, 32'h0000_0023, 32'h0,         32'hFFFF_FF81, 1'b0, 2};

        mem_if.MEM_req_valid   = 1'b0;
        mem_if.MEM_req_write   = 1'b0;
        mem_if.MEM_length      = 2'b00;
        mem_if.MEM_read_signed = 1'b0;
        mem_if.MEM_address     = 32'h0;
        mem_if.MEM_write_data  = 32'h0;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ready", 32'(mem_if.MEM_req_ready), 32'd1);
        chk("reset_resp_valid", 32'(mem_if.MEM_resp_valid), 32'd0);
        chk("reset_read_data", mem_if.MEM_read_data, 32'h0);
        chk("reset_error", 32'(mem_if.MEM_error), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < NV; i++) run_txn(vecs[i], i);

        // Crossing store into untouched words, reset while its second half is pending
        mem_if.MEM_req_valid   = 1'b1;
        mem_if.MEM_req_write   = 1'b1;
        mem_if.MEM_length      = 2'b11;
        mem_if.MEM_read_signed = 1'b0;
        mem_if.MEM_address     = 32'h0000_003E;
        mem_if.MEM_write_data  = 32'hAABB_CCDD;
        chk("mid_reset_ready_before", 32'(mem_if.MEM_req_ready), 32'd1);
        @(posedge clk); #1;
        mem_if.MEM_req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_reset_resp_valid", 32'(mem_if.MEM_resp_valid), 32'd0);
        chk("mid_reset_ready", 32'(mem_if.MEM_req_ready), 32'd1);
        chk("mid_reset_read_data", mem_if.MEM_read_data, 32'h0);
        rst = 1'b0;
        pulses = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (mem_if.MEM_resp_valid) pulses++;
        end
        $display("txn reset-mid-second: resp pulses after reset=%0d", pulses);
        chk("mid_reset_no_pulse", 32'(pulses), 32'd0);

        t = '{1'b0, 2'b11, 1'b0, 32'h0000_003C, 32'h0, 32'hCCDD_0000, 1'b0, 2};
        run_txn(t, 100);
        t = '{1'b0, 2'b11, 1'b0, 32'h0000_0040, 32'h0, 32'h0000_0000, 1'b0, 2};
        run_txn(t, 101);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
